led_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 35 +++
 rtl/led_seq_prescaler.sv | 36 +++
 rtl/led_sequencer.sv | 163 ++++++++++++++++
 tb/tb_led_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: mode encoding, CSR map, CTRL layout.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Bit order matches the CTRL register image: [3] dir, [2] enable, [1:0] mode.
    typedef struct packed {
        logic  dir;
        logic  enable;
        mode_e mode;
    } ctrl_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int unsigned CTRL_MODE_LSB = 0;
    localparam int unsigned CTRL_MODE_W   = 2;
    localparam int unsigned CTRL_EN_BIT   = 2;
    localparam int unsigned CTRL_DIR_BIT  = 3;
    localparam int unsigned CTRL_W        = 4;
    localparam int unsigned LED_W         = 8;
    localparam int unsigned CNT_W         = 8;

    function automatic logic [LED_W-1:0] rotate_led(input logic [LED_W-1:0] v, input logic right);
        return right ? {v[0], v[LED_W-1:1]} : {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: counts 0..period_i and flags a tick on the terminal count.
module led_seq_prescaler #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] period_i,
    output logic             tick_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // A period lowered below the running count lets the counter wrap through 2^WIDTH.
    always_comb begin
        tick_c_o = 1'b0;
        count_d  = count_q + WIDTH'(1);
        if (clear_i || !en_i) begin
            count_d = '0;
        end else if (count_q == period_i) begin
            tick_c_o = 1'b1;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Avalon-MM controlled LED sequencer: static, blink, rotate and bounce modes with a step pulse.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W     = 26,
    parameter int unsigned DEFAULT_PERIOD = 24_999_999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [7:0]  led,
    output logic        step_pulse
);

    ctrl_t                  ctrl_q,     ctrl_d;
    logic [LED_W-1:0]       pattern_q,  pattern_d;
    logic [PRESCALE_W-1:0]  period_q,   period_d;
    logic [LED_W-1:0]       work_q,     work_d;
    logic                   phase_q,    phase_d;
    logic                   bdir_q,     bdir_d;
    logic [CNT_W-1:0]       step_cnt_q, step_cnt_d;
    logic [LED_W-1:0]       led_q,      led_d;
    logic                   pulse_q;
    logic [31:0]            rdata_q,    rdata_d;
    logic                   rvalid_q;

    logic wr_ctrl_c;
    logic wr_pattern_c;
    logic restart_c;
    logic tick_c;
    logic step_c;
    logic unused_wdata_c;

    assign unused_wdata_c = ^avs_writedata;

    led_seq_prescaler #(
        .WIDTH (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (restart_c),
        .en_i     (ctrl_q.enable),
        .period_i (period_q),
        .tick_c_o (tick_c)
    );

    // Register writes, restart handling and the per-mode step datapath.
    always_comb begin
        ctrl_d     = ctrl_q;
        pattern_d  = pattern_q;
        period_d   = period_q;
        work_d     = work_q;
        phase_d    = phase_q;
        bdir_d     = bdir_q;
        step_cnt_d = step_cnt_q;

        wr_ctrl_c    = avs_write && (avs_address == ADDR_CTRL);
        wr_pattern_c = avs_write && (avs_address == ADDR_PATTERN);
        restart_c    = wr_ctrl_c || wr_pattern_c;
        step_c       = tick_c && ctrl_q.enable && (ctrl_q.mode != MODE_STATIC) && !restart_c;

        if (wr_ctrl_c) begin
            ctrl_d.mode   = mode_e'(avs_writedata[CTRL_MODE_LSB +: CTRL_MODE_W]);
            ctrl_d.enable = avs_writedata[CTRL_EN_BIT];
            ctrl_d.dir    = avs_writedata[CTRL_DIR_BIT];
        end
        if (wr_pattern_c) begin
            pattern_d = avs_writedata[LED_W-1:0];
        end
        if (avs_write && (avs_address == ADDR_PERIOD)) begin
            period_d = avs_writedata[PRESCALE_W-1:0];
        end

        if (restart_c) begin
            step_cnt_d = '0;
            work_d     = pattern_d;
            phase_d    = 1'b1;
            bdir_d     = ctrl_d.dir;
        end else if (step_c) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
            case (ctrl_q.mode)
                MODE_BLINK:  phase_d = !phase_q;
                MODE_ROTATE: work_d  = rotate_led(work_q, ctrl_q.dir);
                MODE_BOUNCE: begin
                    if (!bdir_q && work_q[LED_W-1]) begin
                        bdir_d = 1'b1;
                        work_d = work_q >> 1;
                    end else if (bdir_q && work_q[0]) begin
                        bdir_d = 1'b0;
                        work_d = work_q << 1;
                    end else begin
                        work_d = bdir_q ? (work_q >> 1) : (work_q << 1);
                    end
                end
                default: ;
            endcase
        end
    end

    // LED image is built from next-state values so a write shows on led right after its edge.
    always_comb begin
        led_d = '0;
        if (ctrl_d.enable) begin
            case (ctrl_d.mode)
                MODE_STATIC: led_d = pattern_d;
                MODE_BLINK:  led_d = phase_d ? pattern_d : '0;
                default:     led_d = work_d;
            endcase
        end
    end

    // Read mux samples current (pre-write) register state.
    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:    rdata_d = {(32 - CTRL_W)'(0), ctrl_q};
                ADDR_PATTERN: rdata_d = {(32 - LED_W)'(0), pattern_q};
                ADDR_PERIOD:  rdata_d = 32'(period_q);
                default:      rdata_d = {15'd0, bdir_q, step_cnt_q, led_q};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            pattern_q  <= '0;
            period_q   <= PRESCALE_W'(DEFAULT_PERIOD);
            work_q     <= '0;
            phase_q    <= 1'b1;
            bdir_q     <= 1'b0;
            step_cnt_q <= '0;
            led_q      <= '0;
            pulse_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            pattern_q  <= pattern_d;
            period_q   <= period_d;
            work_q     <= work_d;
            phase_q    <= phase_d;
            bdir_q     <= bdir_d;
            step_cnt_q <= step_cnt_d;
            led_q      <= led_d;
            pulse_q    <= step_c;
            rdata_q    <= rdata_d;
            rvalid_q   <= avs_read;
        end
    end

    assign led               = led_q;
    assign step_pulse        = pulse_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: queued read and LED expectations checked by a monitor.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  led;
    logic        step_pulse;

    localparam logic [31:0] DEF_PERIOD = 32'd24_999_999;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  led;
        logic        pulse;
    } led_exp_t;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    led_exp_t    led_q[$];
    rd_exp_t     rd_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    led_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .led               (led),
        .step_pulse        (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares queued LED expectations by cycle and read data on readdatavalid.
    always begin
        @(negedge clk);
        #1;
        while (led_q.size() > 0 && led_q[0].cyc <= cyc) begin
            led_exp_t e;
            e = led_q.pop_front();
            checks++;
            if (e.cyc != cyc || led !== e.led || step_pulse !== e.pulse) begin
                errors++;
                $display("FAIL led@%0d (now %0d): got led=%h pulse=%b, want led=%h pulse=%b",
                         e.cyc, cyc, led, step_pulse, e.led, e.pulse);
            end
        end
        if (avs_readdatavalid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_readdatavalid: got data=%h, want no valid", avs_readdata);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                if (avs_readdata !== r.data) begin
                    errors++;
                    $display("FAIL read_%s: got %h, want %h", r.name, avs_readdata, r.data);
                end
            end
        end
    end

    function automatic void push_led(input int unsigned off, input logic [7:0] l, input logic p);
        led_exp_t e;
        e.cyc = cyc + off;
        e.led = l;
        e.pulse = p;
        led_q.push_back(e);
    endfunction

    // All bus tasks are entered and left at a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_exp_t r;
        r.data = exp;
        r.name = name;
        rd_q.push_back(r);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        rd_exp_t r;
        r.data = exp;
        r.name = name;
        rd_q.push_back(r);
        avs_address = a;
        avs_writedata = d;
        avs_read = 1'b1;
        avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic check_async(input string name, input logic [9:0] got);
        checks++;
        if (got !== 10'd0) begin
            errors++;
            $display("FAIL %s: got {led,pulse,rvalid}=%b, want all zero", name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bounce_tbl [15];
        bounce_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset values
        repeat (3) @(negedge clk);
        check_async("reset_outputs", {led, step_pulse, avs_readdatavalid});
        reset = 1'b0;
        push_led(0, 8'h00, 1'b0);
        push_led(2, 8'h00, 1'b0);
        rd(2'd0, 32'd0, "ctrl_reset");
        rd(2'd1, 32'd0, "pattern_reset");
        rd(2'd2, DEF_PERIOD, "period_reset");
        rd(2'd3, 32'd0, "status_reset");

        // Blink, period 3
        wr(2'd2, 32'd3);
        wr(2'd1, 32'h5A);
        wr(2'd0, 32'h5);
        push_led(0, 8'h5A, 1'b0);
        push_led(3, 8'h5A, 1'b0);
        push_led(4, 8'h00, 1'b1);
        push_led(5, 8'h00, 1'b0);
        push_led(8, 8'h5A, 1'b1);
        push_led(9, 8'h5A, 1'b0);
        repeat (9) @(negedge clk);
        rd(2'd3, 32'h0000_025A, "status_blink");

        // Rotate left then right, period 0
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h81);
        wr(2'd0, 32'h6);
        push_led(0, 8'h81, 1'b0);
        push_led(1, 8'h03, 1'b1);
        push_led(2, 8'h06, 1'b1);
        push_led(3, 8'h0C, 1'b1);
        push_led(4, 8'h18, 1'b1);
        repeat (4) @(negedge clk);
        wr(2'd0, 32'hE);
        push_led(0, 8'h81, 1'b0);
        push_led(1, 8'hC0, 1'b1);
        push_led(2, 8'h60, 1'b1);
        push_led(3, 8'h30, 1'b1);
        repeat (3) @(negedge clk);

        // Bounce from 0x01, dir left
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h7);
        push_led(0, 8'h01, 1'b0);
        for (int k = 0; k < 15; k++) push_led(k + 1, bounce_tbl[k], 1'b1);
        repeat (9) @(negedge clk);
        rd(2'd3, 32'h0001_0920, "status_bounce_right");
        repeat (5) @(negedge clk);
        rd(2'd3, 32'h0000_0F02, "status_bounce_left");

        // Pattern write coinciding with a tick
        wr(2'd2, 32'd3);
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h6);
        push_led(0, 8'h01, 1'b0);
        push_led(3, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        wr(2'd1, 32'h3C);
        push_led(0, 8'h3C, 1'b0);
        push_led(3, 8'h3C, 1'b0);
        push_led(4, 8'h78, 1'b1);
        rd(2'd3, 32'h0000_003C, "status_after_collide");
        repeat (3) @(negedge clk);
        rw(2'd1, 32'hA5, 32'h0000_003C, "pattern_read_during_write");
        push_led(0, 8'hA5, 1'b0);

        // Reset in the middle of a rotate
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h6);
        push_led(0, 8'hA5, 1'b0);
        push_led(1, 8'h4B, 1'b1);
        push_led(2, 8'h96, 1'b1);
        push_led(3, 8'h2D, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_async("async_reset", {led, step_pulse, avs_readdatavalid});
        @(negedge clk);
        reset = 1'b0;
        push_led(0, 8'h00, 1'b0);
        push_led(4, 8'h00, 1'b0);
        rd(2'd2, DEF_PERIOD, "period_after_reset");
        rd(2'd0, 32'd0, "ctrl_after_reset");
        rd(2'd3, 32'd0, "status_after_reset");
        repeat (4) @(negedge clk);
        #2;

        checks++;
        if (led_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d led and %0d read expectations pending, want 0 and 0",
                     led_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
